// File: rtl/uart_word_tx.sv
// ============================================================================
//  Module      : uart_word_tx
//  Description : Multi-word UART transmitter. Accepts one W_OUT-bit payload
//                on a valid/ready handshake and sends it as NUM_WORDS
//                back-to-back 8N1-style frames. Word 0 goes first, and each
//                frame is sent LSB first.
//  Ports       : clk     - system clock, rising edge
//                rst     - asynchronous reset, active-high
//                s_valid - payload valid
//                s_data  - payload, s_data[0] transmitted first
//                s_ready - idle, able to accept a payload
//                tx      - serial line, idle high, registered
//                busy    - inverse of s_ready
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_word_tx #(
    parameter int  CLOCKS_PER_PULSE = 5208,
    parameter int  BITS_PER_WORD    = 8,
    parameter int  W_OUT            = 16,
    localparam int NUM_WORDS        = W_OUT / BITS_PER_WORD
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    s_valid,
    input  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] s_data,
    output logic                                    s_ready,
    output logic                                    tx,
    output logic                                    busy
);

    localparam int BAUD_W = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BIT_W  = (BITS_PER_WORD > 1)    ? $clog2(BITS_PER_WORD)    : 1;
    localparam int WORD_W = (NUM_WORDS > 1)        ? $clog2(NUM_WORDS)        : 1;

    localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BIT_W-1:0]  c_BIT_LAST  = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [WORD_W-1:0] c_WORD_LAST = WORD_W'(NUM_WORDS - 1);

    if ((W_OUT % BITS_PER_WORD) != 0 || W_OUT < BITS_PER_WORD) begin : g_bad_width
        $error("uart_word_tx: W_OUT must be a non-zero multiple of BITS_PER_WORD");
    end
    if (CLOCKS_PER_PULSE < 2) begin : g_bad_baud
        $error("uart_word_tx: CLOCKS_PER_PULSE must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                                  r_state, w_state;
    logic [BAUD_W-1:0]                       r_baud,  w_baud;
    logic [BIT_W-1:0]                        r_bit,   w_bit;
    logic [WORD_W-1:0]                       r_word,  w_word;
    logic [BITS_PER_WORD-1:0]                r_shift, w_shift;
    logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] r_payload, w_payload;
    logic                                    r_tx,    w_tx;
    logic                                    w_baud_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_word    <= '0;
            r_shift   <= '0;
            r_payload <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state;
            r_baud    <= w_baud;
            r_bit     <= w_bit;
            r_word    <= w_word;
            r_shift   <= w_shift;
            r_payload <= w_payload;
            r_tx      <= w_tx;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_baud     = r_baud;
        w_bit      = r_bit;
        w_word     = r_word;
        w_shift    = r_shift;
        w_payload  = r_payload;
        w_baud_end = (r_baud == c_BAUD_LAST);

        // Every bit period of every non-idle state has the same length.
        if (r_state != S_IDLE) begin
            w_baud = w_baud_end ? '0 : r_baud + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (s_valid) begin
                    w_state   = S_START;
                    w_payload = s_data;
                    w_word    = '0;
                    w_bit     = '0;
                    w_baud    = '0;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_state = S_DATA;
                    w_bit   = '0;
                    w_shift = r_payload[r_word];
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    if (r_bit == c_BIT_LAST) begin
                        w_state = S_STOP;
                    end else begin
                        w_bit   = r_bit + 1'b1;
                        w_shift = r_shift >> 1;
                    end
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    if (r_word == c_WORD_LAST) begin
                        w_state = S_IDLE;
                    end else begin
                        w_word  = r_word + 1'b1;
                        w_state = S_START;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase

        // The line level is derived from the next state, so the registered tx
        // changes on the same edge as the state it belongs to.
        w_tx = 1'b1;
        if (w_state == S_START) begin
            w_tx = 1'b0;
        end else if (w_state == S_DATA) begin
            w_tx = w_shift[0];
        end
    end

    assign tx      = r_tx;
    assign s_ready = (r_state == S_IDLE);
    assign busy    = ~s_ready;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_tx.sv
// ============================================================================
//  Module      : tb_uart_word_tx
//  Description : Self-checking bench for uart_word_tx (CPP=4, 8 bits, 16-bit
//                payload). Table vectors, reset corner cases and randomized
//                payloads checked cycle by cycle and by a line decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_word_tx;

    localparam int CPP   = 4;
    localparam int BPW   = 8;
    localparam int WOUT  = 16;
    localparam int NW    = WOUT / BPW;
    localparam int FRAME = BPW + 2;
    localparam int SEQ   = NW * FRAME;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   s_valid = 1'b0;
    logic [NW-1:0][BPW-1:0] s_data = '0;
    logic                   s_ready;
    logic                   tx;
    logic                   busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic        rx_en = 1'b0;
    logic [15:0] rx_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] rx_w;
    logic [7:0]  rx_b;
    int          rx_nb = 0;

    uart_word_tx #(
        .CLOCKS_PER_PULSE(CPP),
        .BITS_PER_WORD   (BPW),
        .W_OUT           (WOUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_valid(s_valid),
        .s_data (s_data),
        .s_ready(s_ready),
        .tx     (tx),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]   data;
        logic [0:SEQ-1] seq;
        logic          keep;  // hold s_valid high with the next entry's data
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected line bit sequence built directly from the framing rules.
    function automatic logic [0:SEQ-1] model_seq(input logic [15:0] d);
        logic [0:SEQ-1] s;
        logic [7:0]     b;
        for (int w = 0; w < NW; w++) begin
            b = d[w*BPW +: BPW];
            s[w*FRAME] = 1'b0;
            for (int j = 0; j < BPW; j++) s[w*FRAME + 1 + j] = b[j];
            s[w*FRAME + FRAME - 1] = 1'b1;
        end
        return s;
    endfunction

    // Called at a falling edge with the DUT idle. Checks every cycle of the
    // transfer and the first cycle after it.
    task automatic send_check(input logic [15:0] d, input logic [0:SEQ-1] seq,
                              input logic keep, input logic [15:0] d_next);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        #1;
        if (keep) s_data = d_next;
        else      s_valid = 1'b0;
        for (int i = 0; i < SEQ*CPP; i++) begin
            @(negedge clk);
            chk("tx_bit", tx, seq[i/CPP]);
            chk("ready_busy", {s_ready, busy}, 2'b01);
        end
        @(negedge clk);
        chk("end_ready", s_ready, 1'b1);
        chk("end_tx", tx, 1'b1);
    endtask

    // Behavioural line decoder: mid-bit sampling, assembles NW frames per word.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_en && tx === 1'b0) begin
                repeat (CPP/2) @(negedge clk);
                chk("rx_start", tx, 1'b0);
                for (int j = 0; j < BPW; j++) begin
                    repeat (CPP) @(negedge clk);
                    rx_b[j] = tx;
                end
                repeat (CPP) @(negedge clk);
                chk("rx_stop", tx, 1'b1);
                rx_w[rx_nb*BPW +: BPW] = rx_b;
                rx_nb++;
                if (rx_nb == NW) begin
                    rx_q.push_back(rx_w);
                    rx_nb = 0;
                end
            end
        end
    end

    initial begin
        logic [15:0] d;

        vecs[0] = '{data: 16'hA55A, seq: 20'b0010110101_0101001011, keep: 1'b0};
        vecs[1] = '{data: 16'hA55A, seq: 20'b0010110101_0101001011, keep: 1'b1};
        vecs[2] = '{data: 16'h0F0F, seq: 20'b0111100001_0111100001, keep: 1'b0};
        vecs[3] = '{data: 16'h0000, seq: 20'b0000000001_0000000001, keep: 1'b1};
        vecs[4] = '{data: 16'hFFFF, seq: 20'b0111111111_0111111111, keep: 1'b0};

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", s_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tx", tx, 1'b1);
        chk("post_rst_ready", s_ready, 1'b1);

        // Table vectors: plain transfer, ignore-while-busy, back-to-back
        for (int i = 0; i < 5; i++) begin
            send_check(vecs[i].data, vecs[i].seq, vecs[i].keep,
                       (i < 4) ? vecs[i+1].data : 16'h0000);
        end

        // Reset during data bit 3 of word 0
        s_valid = 1'b1;
        s_data  = 16'h0000;
        @(posedge clk);
        #1 s_valid = 1'b0;
        repeat (CPP*4 + 2) @(negedge clk);
        chk("pre_rst_tx", tx, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx", tx, 1'b1);
        chk("async_rst_ready", s_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", s_ready, 1'b1);
        chk("rel_tx", tx, 1'b1);
        chk("rel_busy", busy, 1'b0);
        send_check(16'h1234, 20'b0001011001_0010010001, 1'b0, 16'h0000);

        // Randomized payloads, checked per cycle and through the decoder
        rx_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            d = 16'($urandom);
            exp_q.push_back(d);
            send_check(d, model_seq(d), 1'b0, 16'h0000);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("idle_tx", tx, 1'b1);
            end
        end
        repeat (4) @(negedge clk);
        rx_en = 1'b0;
        chk("rx_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) chk("rx_data", rx_q[i], exp_q[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
